// File: rtl/bram_burst_buffer_pkg.sv
// Shared FSM state types and sizing helpers for bram_burst_buffer.
package bram_burst_pkg;

  typedef enum logic {
    WR_IDLE,
    WR_WRITE
  } wr_state_e;

  typedef enum logic {
    RD_IDLE,
    RD_READ
  } rd_state_e;

  // RAM address width for a power-of-two depth of at least 2.
  function automatic int addr_width(input int depth);
    return $clog2(depth);
  endfunction

  // Out-of-range burst lengths (0 or more than depth) mean a full-depth burst.
  function automatic int len_clamp(input int len, input int depth);
    return ((len == 0) || (len > depth)) ? depth : len;
  endfunction

endpackage

// File: rtl/bram_burst_buffer_sdp_bram.sv
// Simple dual-port RAM with registered, read-first read port, shaped for
// block-RAM inference. The reset only clears the read register, never the array.
module sdp_bram #(
  parameter int WIDTH  = 4,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clock) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Non-blocking read of the array gives old contents on a same-address write.
  always_ff @(posedge clock) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (re) begin
      rdata_q <= mem_q[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/bram_burst_buffer.sv
// Multi-channel burst capture/replay buffer over an inferred SDP block RAM.
// Define BRAM_BURST_LOOP_READ_EN for continuous looped replay ended by a stop input.
module bram_burst_buffer
  import bram_burst_pkg::*;
#(
  parameter int  DATA_W = 4,
  parameter int  NUM_CH = 1,
  parameter int  DEPTH  = 8,
  localparam int ADDR_W = addr_width(DEPTH),
  localparam int LEN_W  = ADDR_W + 1,
  localparam int WORD_W = DATA_W * NUM_CH
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              load,
  input  logic              start,
  input  logic [LEN_W-1:0]  burst_len,
  input  logic [WORD_W-1:0] data_in,
`ifdef BRAM_BURST_LOOP_READ_EN
  input  logic              stop,
`endif
  output logic              wr_busy,
  output logic              wr_done,
  output logic              rd_busy,
  output logic [WORD_W-1:0] data_out,
  output logic              out_valid,
  output logic              out_last
);

  function automatic logic [ADDR_W-1:0] last_index(input logic [LEN_W-1:0] len);
    return ADDR_W'(len_clamp(int'(len), DEPTH) - 1);
  endfunction

  // ---------------- write controller ----------------
  wr_state_e         wr_state_q, wr_state_d;
  logic [ADDR_W-1:0] wr_addr_q,  wr_addr_d;
  logic [ADDR_W-1:0] wr_last_q,  wr_last_d;
  logic              wr_done_q,  wr_done_d;

  always_ff @(posedge clock) begin
    if (rst) begin
      wr_state_q <= WR_IDLE;
      wr_addr_q  <= '0;
      wr_last_q  <= '0;
      wr_done_q  <= 1'b0;
    end else begin
      wr_state_q <= wr_state_d;
      wr_addr_q  <= wr_addr_d;
      wr_last_q  <= wr_last_d;
      wr_done_q  <= wr_done_d;
    end
  end

  always_comb begin
    wr_state_d = wr_state_q;
    wr_addr_d  = wr_addr_q;
    wr_last_d  = wr_last_q;
    wr_done_d  = 1'b0;
    case (wr_state_q)
      WR_IDLE: begin
        if (load) begin
          wr_state_d = WR_WRITE;
          wr_addr_d  = '0;
          wr_last_d  = last_index(burst_len);
        end
      end
      WR_WRITE: begin
        // The counter parks at the last index, so it never wraps mid-burst.
        if (wr_addr_q == wr_last_q) begin
          wr_state_d = WR_IDLE;
          wr_addr_d  = '0;
          wr_done_d  = 1'b1;
        end else begin
          wr_addr_d = wr_addr_q + ADDR_W'(1);
        end
      end
      default: wr_state_d = WR_IDLE;
    endcase
  end

  // ---------------- read controller ----------------
  rd_state_e         rd_state_q, rd_state_d;
  logic [ADDR_W-1:0] rd_addr_q,  rd_addr_d;
  logic [ADDR_W-1:0] rd_last_q,  rd_last_d;
  logic              out_valid_q, out_valid_d;
  logic              out_last_q,  out_last_d;

  always_ff @(posedge clock) begin
    if (rst) begin
      rd_state_q  <= RD_IDLE;
      rd_addr_q   <= '0;
      rd_last_q   <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      rd_state_q  <= rd_state_d;
      rd_addr_q   <= rd_addr_d;
      rd_last_q   <= rd_last_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end

  always_comb begin
    rd_state_d  = rd_state_q;
    rd_addr_d   = rd_addr_q;
    rd_last_d   = rd_last_q;
    // Valid/last track the issued address one cycle later, aligned with RAM latency.
    out_valid_d = (rd_state_q == RD_READ);
    out_last_d  = (rd_state_q == RD_READ) && (rd_addr_q == rd_last_q);
    case (rd_state_q)
      RD_IDLE: begin
        if (start) begin
          rd_state_d = RD_READ;
          rd_addr_d  = '0;
          rd_last_d  = last_index(burst_len);
        end
      end
      RD_READ: begin
`ifdef BRAM_BURST_LOOP_READ_EN
        if (stop) begin
          rd_state_d = RD_IDLE;
          rd_addr_d  = '0;
        end else if (rd_addr_q == rd_last_q) begin
          rd_addr_d = '0;
        end else begin
          rd_addr_d = rd_addr_q + ADDR_W'(1);
        end
`else
        if (rd_addr_q == rd_last_q) begin
          rd_state_d = RD_IDLE;
          rd_addr_d  = '0;
        end else begin
          rd_addr_d = rd_addr_q + ADDR_W'(1);
        end
`endif
      end
      default: rd_state_d = RD_IDLE;
    endcase
  end

  // ---------------- storage ----------------
  logic ram_we;
  logic ram_re;

  assign ram_we = (wr_state_q == WR_WRITE);
  assign ram_re = (rd_state_q == RD_READ);

  // The read register only loads on issued addresses, so data_out holds between bursts.
  sdp_bram #(
    .WIDTH  (WORD_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clock (clock),
    .rst   (rst),
    .we    (ram_we),
    .waddr (wr_addr_q),
    .wdata (data_in),
    .re    (ram_re),
    .raddr (rd_addr_q),
    .rdata (data_out)
  );

  assign wr_busy   = ram_we;
  assign wr_done   = wr_done_q;
  assign rd_busy   = ram_re;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_bram_burst_buffer.sv
// Bench for bram_burst_buffer (2 channels x 4 bits, depth 8): directed bursts with
// literal expectations plus random traffic against a cycle-schedule model.
module tb_bram_burst_buffer;

  localparam int DW  = 4;
  localparam int NC  = 2;
  localparam int DEP = 8;
  localparam int W   = DW * NC;
  localparam int LW  = 4;

  logic          clock = 1'b0;
  logic          rst = 1'b1;
  logic          load = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic [LW-1:0] burst_len = '0;
  logic [W-1:0]  data_in = '0;
  logic          wr_busy, wr_done, rd_busy, out_valid, out_last;
  logic [W-1:0]  data_out;

  always #5 clock = ~clock;

  bram_burst_buffer #(
    .DATA_W (DW),
    .NUM_CH (NC),
    .DEPTH  (DEP)
  ) dut (
    .clock     (clock),
    .rst       (rst),
    .load      (load),
    .start     (start),
    .burst_len (burst_len),
    .data_in   (data_in),
`ifdef BRAM_BURST_LOOP_READ_EN
    .stop      (stop),
`endif
    .wr_busy   (wr_busy),
    .wr_done   (wr_done),
    .rd_busy   (rd_busy),
    .data_out  (data_out),
    .out_valid (out_valid),
    .out_last  (out_last)
  );

  int    vectors = 0;
  int    miscompares = 0;
  longint cyc = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // ---------------- behavioural model ----------------
  // Each burst is a window of cycles [start, end); the model derives every output
  // from where the current cycle sits in those windows.
  longint     wr_start = 0, wr_end = 0, rd_start = 0, rd_end = 0;
  int         rd_n = 1;
  logic [W-1:0] mem_m [DEP];
  bit         mem_ok [DEP];
  logic       exp_wr_busy = 0, exp_wr_done = 0, exp_rd_busy = 0, exp_valid = 0, exp_last = 0;
  logic [W-1:0] exp_data = '0;
  bit         exp_data_ok = 1;

  function automatic int eff_len(input logic [LW-1:0] l);
    int v;
    v = int'(l);
    if (v == 0 || v > DEP) v = DEP;
    return v;
  endfunction

  initial begin
    for (int i = 0; i < DEP; i++) mem_ok[i] = 0;
    forever begin
      bit wr_act, rd_act, r_ok, r_last;
      logic [W-1:0] r_word;
      int k;
      @(posedge clock);
      wr_act = (cyc >= wr_start) && (cyc < wr_end);
      rd_act = (cyc >= rd_start) && (cyc < rd_end);
      r_ok = 0; r_last = 0; r_word = '0;
      if (rd_act) begin
        k = int'((cyc - rd_start) % longint'(rd_n));
        r_word = mem_m[k];
        r_ok   = mem_ok[k];
        r_last = (k == rd_n - 1);
      end
      if (wr_act) begin
        mem_m[int'(cyc - wr_start)]  = data_in;
        mem_ok[int'(cyc - wr_start)] = 1;
      end
      if (rst) begin
        wr_start = 0; wr_end = 0; rd_start = 0; rd_end = 0;
        exp_wr_busy = 0; exp_wr_done = 0; exp_rd_busy = 0;
        exp_valid = 0; exp_last = 0; exp_data = '0; exp_data_ok = 1;
      end else begin
        exp_wr_done = wr_act && (cyc + 1 == wr_end);
        exp_valid   = rd_act;
        exp_last    = rd_act && r_last;
        if (rd_act) begin
          exp_data    = r_word;
          exp_data_ok = r_ok;
        end
        if (load && !wr_act) begin
          wr_start = cyc + 1;
          wr_end   = cyc + 1 + longint'(eff_len(burst_len));
        end
`ifdef BRAM_BURST_LOOP_READ_EN
        if (stop && rd_act) rd_end = cyc + 1;
        if (start && !rd_act) begin
          rd_start = cyc + 1;
          rd_n     = eff_len(burst_len);
          rd_end   = 64'h7FFF_FFFF_FFFF_FFFF;
        end
`else
        if (start && !rd_act) begin
          rd_start = cyc + 1;
          rd_n     = eff_len(burst_len);
          rd_end   = cyc + 1 + longint'(rd_n);
        end
`endif
        exp_wr_busy = (cyc + 1 >= wr_start) && (cyc + 1 < wr_end);
        exp_rd_busy = (cyc + 1 >= rd_start) && (cyc + 1 < rd_end);
      end
      cyc++;
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    @(posedge clock);
    forever begin
      @(negedge clock);
      chk("wr_busy",   32'(wr_busy),   32'(exp_wr_busy));
      chk("wr_done",   32'(wr_done),   32'(exp_wr_done));
      chk("rd_busy",   32'(rd_busy),   32'(exp_rd_busy));
      chk("out_valid", 32'(out_valid), 32'(exp_valid));
      chk("out_last",  32'(out_last),  32'(exp_last));
      if (exp_data_ok) chk("data_out", 32'(data_out), 32'(exp_data));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input bit l, input bit s, input int len, input logic [W-1:0] d);
    load = l; start = s; burst_len = LW'(len); data_in = d;
    @(posedge clock); #1;
    load = 0; start = 0; stop = 0; data_in = W'($urandom);
  endtask

  logic [W-1:0] d3 [3];
  int cnt;

  initial begin
    d3[0] = 8'h05; d3[1] = 8'h0A; d3[2] = 8'h0F;
    rst = 1;
    repeat (3) @(posedge clock);
    #1 rst = 0;
    chk("reset_out_valid", 32'(out_valid), 0);
    chk("reset_data_out",  32'(data_out),  0);

    // Full-depth burst, values 0..7
    tick(1, 0, 8, 0);
    for (int k = 0; k < 8; k++) tick(0, 0, 0, W'(k));
    chk("t1_wr_done_at_9", 32'(wr_done), 1);
    tick(0, 1, 8, 0);
    tick(0, 0, 0, 0);
    for (int k = 0; k < 8; k++) begin
      chk("t1_valid", 32'(out_valid), 1);
      chk("t1_data",  32'(data_out),  k);
      chk("t1_last",  32'(out_last),  (k == 7) ? 1 : 0);
      tick(0, 0, 0, 0);
    end
    chk("t1_valid_after", 32'(out_valid), 0);
    $display("txn: write N=8 then read N=8");

    // N=3 burst, busy window length
    tick(1, 0, 3, 0);
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      cnt += int'(wr_busy);
      tick(0, 0, 0, (i < 3) ? d3[i] : 8'h00);
    end
    chk("t2_wr_busy_cycles", 32'(cnt), 3);
    tick(0, 1, 3, 0);
    tick(0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      chk("t2_data", 32'(data_out), 32'(d3[k]));
      chk("t2_last", 32'(out_last), (k == 2) ? 1 : 0);
      tick(0, 0, 0, 0);
    end
    $display("txn: write/read N=3");

    // burst_len=0 means a full-depth read
    tick(0, 1, 0, 0);
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      tick(0, 0, 0, 0);
      cnt += int'(out_valid);
    end
    chk("t2_len0_words", 32'(cnt), 8);
    $display("txn: read burst_len=0");

    // Two channels side by side
    tick(1, 0, 2, 0);
    tick(0, 0, 0, 8'h21);
    tick(0, 0, 0, 8'h43);
    tick(0, 1, 2, 0);
    tick(0, 0, 0, 0);
    chk("t3_word0", 32'(data_out), 32'h21);
    tick(0, 0, 0, 0);
    chk("t3_word1", 32'(data_out), 32'h43);
    chk("t3_last",  32'(out_last), 1);
    $display("txn: two-channel N=2");

    // Concurrent load and start: read-first collisions return old words
    tick(1, 0, 4, 0);
    for (int k = 0; k < 4; k++) tick(0, 0, 0, W'(k));
    tick(1, 1, 4, 0);
    for (int k = 0; k < 4; k++) begin
      tick(0, 0, 0, W'(9 + k));
      chk("t4_old_data", 32'(data_out), k);
    end
    tick(0, 1, 4, 0);
    tick(0, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      chk("t4_new_data", 32'(data_out), 9 + k);
      tick(0, 0, 0, 0);
    end
    $display("txn: concurrent load/start N=4");

    // Reset in the 3rd cycle of a read burst
    tick(0, 1, 8, 0);
    tick(0, 0, 0, 0);
    tick(0, 0, 0, 0);
    rst = 1;
    tick(0, 0, 0, 0);
    rst = 0;
    chk("t5_valid_after_rst", 32'(out_valid), 0);
    chk("t5_busy_after_rst",  32'(rd_busy),   0);
    tick(0, 1, 8, 0);
    tick(0, 0, 0, 0);
    chk("t5_replay_addr0", 32'(data_out), 32'h09);
    repeat (10) tick(0, 0, 0, 0);
    $display("txn: reset mid-read and replay");

`ifdef BRAM_BURST_LOOP_READ_EN
    tick(1, 0, 4, 0);
    for (int k = 0; k < 4; k++) tick(0, 0, 0, W'(k));
    tick(0, 1, 4, 0);
    tick(0, 0, 0, 0);
    for (int j = 0; j < 10; j++) begin
      chk("loop_data", 32'(data_out), j % 4);
      chk("loop_last", 32'(out_last), ((j % 4) == 3) ? 1 : 0);
      tick(0, 0, 0, 0);
    end
    stop = 1;
    tick(0, 0, 0, 0);
    chk("loop_stop_valid", 32'(out_valid), 1);
    chk("loop_stop_busy",  32'(rd_busy),   0);
    tick(0, 0, 0, 0);
    chk("loop_stop_after", 32'(out_valid), 0);
    $display("txn: looped read with stop");
`endif

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      rst       = ($urandom_range(0, 299) == 0);
      load      = ($urandom_range(0, 5) == 0);
      start     = ($urandom_range(0, 5) == 0);
      stop      = ($urandom_range(0, 15) == 0);
      burst_len = LW'($urandom);
      data_in   = W'($urandom);
      @(posedge clock); #1;
    end
    rst = 0; load = 0; start = 0; stop = 1;
    repeat (12) @(posedge clock);
    #1;
    $display("txn: random traffic, 3000 cycles");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
